regfile: RTL and testbench
==========================

# regfile

General-purpose register file for the openMips pipeline: 32 × 32-bit registers with two combinational read ports and one synchronous write port. It is the responder to the ID stage's `reg1_read_o/reg1_addr_o` and `reg2_read_o/reg2_addr_o` requests. Its read data returns on `reg1_data_i/reg2_data_i`, and write-back drives its write port. Register `$0` is hardwired to zero. A same-cycle write-to-read bypass lets a value written in cycle N be read by ID in cycle N.

## Interface
- No module parameters. Widths come from the shared defines:
  - `RegBus` = 32 bits
  - `RegAddrBus` = 5 bits
  - `RegNum` = 32 entries
  - `RegNumLog2` = 5
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high (`Enable`) reset, sampled on the rising edge of `clk`.
- `we` input 1: write enable (`Enable`/`Disable`).
- `waddr` input `RegAddrBus`: write register index.
- `wdata` input `RegBus`: write data.
- `re1` input 1: read port 1 enable (from `reg1_read_o`).
- `raddr1` input `RegAddrBus`: read port 1 index.
- `rdata1` output `RegBus`: read port 1 data (to `reg1_data_i`).
- `re2` input 1: read port 2 enable.
- `raddr2` input `RegAddrBus`: read port 2 index.
- `rdata2` output `RegBus`: read port 2 data.

## Operation
- Storage: array `regs[0..31]` of `RegBus`. `regs[0]` is never written and always reads `ZeroWord`.
- Write, on a rising edge of `clk`:
  - if `rst` = `Enable`: all 32 entries ← `ZeroWord`;
  - else if `we` = `Enable` and `waddr` ≠ 0: `regs[waddr]` ← `wdata`;
  - else: no change. A write to `$0` is silently dropped.
- Read, port k ∈ {1,2}, combinational, first match wins:
  1. `rst` = `Enable` → `ZeroWord`.
  2. `raddrk` = 0 → `ZeroWord`, even if a write to 0 is presented.
  3. `rek` = `Enable`, `we` = `Enable` and `raddrk` = `waddr` → `wdata` (bypass).
  4. `rek` = `Enable` → `regs[raddrk]`.
  5. otherwise (`rek` = `Disable`) → `ZeroWord`.
- The two ports are fully independent. Both may address the same register, and both may bypass simultaneously.
- No handshake and no stall: every request is served in the same cycle.

## Timing
- Read latency is 0 cycles (purely combinational from `raddrk`, `rek`, `we`, `waddr`, `wdata`, `rst`).
- A write presented in cycle N is:
  - visible to reads in cycle N through the bypass;
  - visible from storage in cycle N+1 and onward.
- Reset values:
  - `rdata1` = `rdata2` = `ZeroWord` whenever `rst` is high;
  - after the first `clk` edge with `rst` high, all entries are zero.
- Reset mid-operation: when `rst` and `we` are both high at the same edge, reset wins and the write is lost.
- Back-to-back writes to the same index: the last edge wins. A read in the same cycle as the second write returns the second write's `wdata`.
- Outputs must not depend on `clk` except through stored state. There are no latches: every read path assigns in every branch.

## Structure
- The existing defines file gets new entries: `RegNum` (32), `RegNumLog2` (5), `RegWidth` (32).
- `Enable`, `Disable`, `ZeroWord` and `NOPRegAddr` are reused as-is.
- The two read ports are identical. Implement them as one `regfile_rdport` sub-module instantiated twice. It takes `rst`, `re`, `raddr`, `we`, `waddr`, `wdata` and the selected stored word, and outputs the read data.
- Storage and write logic stay in `regfile`.
- The top-level wiring connects `id.reg{1,2}_read_o/addr_o` → `re{1,2}/raddr{1,2}` and `rdata{1,2}` → `id.reg{1,2}_data_i`.

## Test plan
- **Reset:** hold `rst`=1 for 2 edges with `we`=1, `waddr`=5, `wdata`=32'hDEADBEEF. Then release `rst` and read port 1 at addr 5 with `re1`=1 → `rdata1` = 0 throughout, including after release.
- **Write/read:** write 32'h1234_5678 to `$3` at edge N. In cycle N+1 set `we`=0, `re1`=1, `raddr1`=3 and `re2`=1, `raddr2`=3 → both ports read 32'h1234_5678.
- **Bypass:** in one cycle set `we`=1, `waddr`=7, `wdata`=32'hCAFE_0001, `re2`=1, `raddr2`=7, while `regs[7]` = 32'h0000_00AA → `rdata2` = 32'hCAFE_0001 in that cycle. It stays 32'hCAFE_0001 the next cycle after `we`=0.
- **`$0` protection:** write 32'hFFFF_FFFF to `waddr`=0 while `re1`=1, `raddr1`=0 → `rdata1` = 0 in that cycle and the next.
- **Read disable:** `regs[4]` = 32'h55 and `re1`=0, `raddr1`=4 → `rdata1` = 0. Set `re1`=1 → `rdata1` = 32'h55 in the same cycle.
- **Reset vs write:** at one edge assert `rst`=1 and `we`=1, `waddr`=9, `wdata`=32'h77. Deassert both and read 9 → 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, control levels and types for the general-purpose register file.
// Imported by the register file top and its read-port sub-module.
package regfile_pkg;

   localparam int REG_BUS      = 32;
   localparam int REG_ADDR_BUS = 5;
   localparam int REG_NUM      = 32;
   localparam int REG_NUM_LOG2 = 5;
   localparam int REG_WIDTH    = 32;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef logic [REG_BUS-1:0]      word_t;
   typedef logic [REG_ADDR_BUS-1:0] addr_t;

   localparam word_t ZERO_WORD   = '0;
   localparam addr_t NOP_REG_ADDR = '0;

   // $0 is hardwired to zero: writes are dropped and reads return ZERO_WORD.
   function automatic logic is_zero_reg(input addr_t addr);
      return addr == NOP_REG_ADDR;
   endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file, including the same-cycle
// write-to-read bypass. Instantiated once per read port.
module regfile_rdport
   import regfile_pkg::*;
(
   input  logic                    rst,
   input  logic                    re,
   input  logic [REG_ADDR_BUS-1:0] raddr,
   input  logic                    we,
   input  logic [REG_ADDR_BUS-1:0] waddr,
   input  logic [REG_BUS-1:0]      wdata,
   input  logic [REG_BUS-1:0]      rword,
   output logic [REG_BUS-1:0]      rdata
);

   always_comb begin
      // NOTE: default first so every path assigns rdata and no latch is inferred.
      rdata = ZERO_WORD;
      if (rst == ENABLE) begin
         rdata = ZERO_WORD;
      end else if (is_zero_reg(raddr)) begin
         rdata = ZERO_WORD;
      end else if (re == ENABLE && we == ENABLE && raddr == waddr) begin
         // Bypass: the word being written this cycle wins over stale storage.
         rdata = wdata;
      end else if (re == ENABLE) begin
         rdata = rword;
      end else begin
         rdata = ZERO_WORD;
      end
   end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit general-purpose register file: one synchronous write port and
// two independent combinational read ports with write-to-read bypass.
module regfile
   import regfile_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [REG_ADDR_BUS-1:0] waddr,
   input  logic [REG_BUS-1:0]      wdata,
   input  logic                    re1,
   input  logic [REG_ADDR_BUS-1:0] raddr1,
   output logic [REG_BUS-1:0]      rdata1,
   input  logic                    re2,
   input  logic [REG_ADDR_BUS-1:0] raddr2,
   output logic [REG_BUS-1:0]      rdata2
);

   word_t regs [REG_NUM];
   word_t rword1;
   word_t rword2;

   // NOTE: the array is cleared by reset because software relies on zeroed
   // registers after reset; this forces flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst == ENABLE) begin
         for (int i = 0; i < REG_NUM; i++) begin
            // NOTE: non-blocking assignment for all sequential state.
            regs[i] <= ZERO_WORD;
         end
      end else if (we == ENABLE && !is_zero_reg(waddr)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rword1 = regs[raddr1];
   assign rword2 = regs[raddr2];

   regfile_rdport u_rdport1 (
      .rst   (rst),
      .re    (re1),
      .raddr (raddr1),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .rword (rword1),
      .rdata (rdata1)
   );

   regfile_rdport u_rdport2 (
      .rst   (rst),
      .re    (re2),
      .raddr (raddr2),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .rword (rword2),
      .rdata (rdata2)
   );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random
// traffic, compared against an array-based reference model.
module tb_regfile;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [32];

   regfile dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected read value from the architectural rules, given current inputs.
   function automatic logic [31:0] exp_read(input logic re, input logic [4:0] addr);
      if (rst)                      return 32'h0;
      if (addr == 5'd0)             return 32'h0;
      if (!re)                      return 32'h0;
      if (we && addr == waddr)      return wdata;
      return model[addr];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2);
      rst = r; we = w; waddr = wa; wdata = wd;
      re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
   endtask

   // Wait to mid-cycle and compare both ports against the model.
   task automatic settle(input string tag);
      @(negedge clk);
      chk({tag, "_p1"}, rdata1, exp_read(re1, raddr1));
      chk({tag, "_p2"}, rdata2, exp_read(re2, raddr2));
   endtask

   // Advance one edge and apply the same edge to the model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (we && waddr != 5'd0) begin
         model[waddr] = wdata;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      drive(1, 1, 5'd5, 32'hDEAD_BEEF, 1, 5'd5, 1, 5'd5);
      #1;

      // Reset held for two edges with a write pending; output stays zero.
      for (int i = 0; i < 2; i++) begin
         settle("rst_hold");
         chk("rst_hold_const", rdata1, 32'h0);
         tick();
      end
      drive(0, 0, 5'd5, 32'hDEAD_BEEF, 1, 5'd5, 0, 5'd0);
      settle("rst_release");
      chk("rst_release_const", rdata1, 32'h0);
      tick();

      // Write then read from storage on both ports.
      drive(0, 1, 5'd3, 32'h1234_5678, 0, 5'd0, 0, 5'd0);
      settle("wr3");
      tick();
      drive(0, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd3);
      settle("rd3");
      chk("rd3_p1_const", rdata1, 32'h1234_5678);
      chk("rd3_p2_const", rdata2, 32'h1234_5678);
      tick();

      // Bypass over an older stored value.
      drive(0, 1, 5'd7, 32'h0000_00AA, 0, 5'd0, 0, 5'd0);
      settle("wr7");
      tick();
      drive(0, 1, 5'd7, 32'hCAFE_0001, 0, 5'd0, 1, 5'd7);
      settle("byp7");
      chk("byp7_const", rdata2, 32'hCAFE_0001);
      tick();
      drive(0, 0, 5'd7, 32'h0, 0, 5'd0, 1, 5'd7);
      settle("after_byp7");
      chk("after_byp7_const", rdata2, 32'hCAFE_0001);
      tick();

      // $0 stays zero even with a write and bypass candidate presented.
      drive(0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 1, 5'd0);
      settle("zero_wr");
      chk("zero_wr_const", rdata1, 32'h0);
      tick();
      drive(0, 0, 5'd0, 32'h0, 1, 5'd0, 0, 5'd0);
      settle("zero_rd");
      chk("zero_rd_const", rdata1, 32'h0);
      tick();

      // Read enable gating.
      drive(0, 1, 5'd4, 32'h0000_0055, 0, 5'd0, 0, 5'd0);
      settle("wr4");
      tick();
      drive(0, 0, 5'd0, 32'h0, 0, 5'd4, 0, 5'd0);
      settle("re_off");
      chk("re_off_const", rdata1, 32'h0);
      re1 = 1'b1;
      #1;
      chk("re_on_const", rdata1, 32'h0000_0055);
      tick();

      // Reset beats a simultaneous write.
      drive(0, 1, 5'd9, 32'h0000_0011, 0, 5'd0, 0, 5'd0);
      settle("wr9");
      tick();
      drive(1, 1, 5'd9, 32'h0000_0077, 1, 5'd9, 1, 5'd4);
      settle("rst_vs_wr");
      tick();
      drive(0, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd4);
      settle("after_rst");
      chk("after_rst9_const", rdata1, 32'h0);
      chk("after_rst4_const", rdata2, 32'h0);
      tick();

      // Back-to-back writes to one index: last wins, bypass shows the newer word.
      drive(0, 1, 5'd12, 32'hAAAA_0001, 0, 5'd0, 0, 5'd0);
      settle("b2b_1");
      tick();
      drive(0, 1, 5'd12, 32'hBBBB_0002, 1, 5'd12, 1, 5'd12);
      settle("b2b_2");
      chk("b2b_2_const", rdata1, 32'hBBBB_0002);
      tick();
      drive(0, 0, 5'd0, 32'h0, 1, 5'd12, 0, 5'd12);
      settle("b2b_after");
      chk("b2b_after_const", rdata1, 32'hBBBB_0002);
      tick();

      // Random traffic; narrow address range half the time to force collisions.
      for (int n = 0; n < 600; n++) begin
         logic        narrow;
         narrow = $urandom_range(1, 0) == 1;
         drive(($urandom_range(39, 0) == 0),
               ($urandom_range(2, 0) != 0),
               narrow ? 5'($urandom_range(3, 0)) : 5'($urandom_range(31, 0)),
               $urandom(),
               ($urandom_range(3, 0) != 0),
               narrow ? 5'($urandom_range(3, 0)) : 5'($urandom_range(31, 0)),
               ($urandom_range(3, 0) != 0),
               narrow ? 5'($urandom_range(3, 0)) : 5'($urandom_range(31, 0)));
         settle("rand");
         tick();
      end

      // Sweep every register through port 2 against the final model contents.
      for (int a = 0; a < 32; a++) begin
         drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'(a));
         settle("sweep");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
